// File: rtl/snn_input_loader_if.sv
// Handshake/bus bundle between snn_input_loader and its UART and SNN-core neighbours.
// The slave modport is the loader's view; master is the environment's view.
interface snn_input_loader_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       start;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       done;
  logic [3:0] digit;
  logic       tx_rdy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;

  modport slave (
    input  rx_rdy, rx_data, addr_input_unit, done, digit, tx_rdy,
    output start, q_input, tx_start, tx_data, busy
  );

  modport master (
    output rx_rdy, rx_data, addr_input_unit, done, digit, tx_rdy,
    input  start, q_input, tx_start, tx_data, busy
  );
endinterface

// File: rtl/snn_input_loader.sv
// Loads a bit-packed image from UART bytes into the SNN input-unit memory, kicks the
// core, serves its bit reads and forwards the classified digit to the UART as ASCII.
module snn_input_loader #(
  parameter int         NUM_BITS   = 784,
  parameter logic [7:0] ASCII_BASE = 8'h30,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic               clk,
  input  logic               rst_n,
  snn_input_loader_if.slave  bus
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES);
  localparam int ADDR_W    = 10;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(NUM_BITS);

  typedef enum logic [1:0] {LOAD, START, WAIT_DONE, SEND} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               start_q, start_d;
  logic               q_input_q, q_input_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               wr_en;
  logic [CNT_W+2:0]   wr_base;
  logic [NUM_BITS-1:0] mem_q;

  assign wr_base = {byte_cnt_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    start_d    = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    wr_en      = 1'b0;
    // Read port is state-independent; out-of-range addresses read as zero.
    q_input_d  = (bus.addr_input_unit < ADDR_LIM) ? mem_q[bus.addr_input_unit] : 1'b0;

    case (state_q)
      LOAD: begin
        if (bus.rx_rdy) begin
          wr_en  = 1'b1;
          busy_d = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            start_d    = 1'b1;
            state_d    = START;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        // A byte coinciding with done is dropped along with every other byte here.
        if (bus.done) begin
          tx_data_d = (bus.digit <= 4'd9) ? (ASCII_BASE + {4'b0000, bus.digit}) : BAD_CHAR;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bus.tx_rdy) begin
          tx_start_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      byte_cnt_q <= '0;
      start_q    <= 1'b0;
      q_input_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      start_q    <= start_d;
      q_input_q  <= q_input_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Image memory keeps its contents across reset; byte k lands LSB-first at 8k.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_base +: 8] <= bus.rx_data;
  end

  assign bus.start    = start_q;
  assign bus.q_input  = q_input_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Randomized bench for snn_input_loader against a bit-array image model and the
// digit-to-character rule.
module tb_snn_input_loader;

  localparam int NUM_BITS  = 784;
  localparam int NUM_BYTES = NUM_BITS / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  snn_input_loader_if bus();

  snn_input_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit        ref_mem [NUM_BITS];
  logic [7:0] img_buf [NUM_BYTES];
  logic [7:0] last_char = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expected_char(input int d);
    if (d <= 9) return 8'(8'h30 + d);
    return 8'h3F;
  endfunction

  // Sends img_buf[0..nbytes-1] with random gaps; start must fire only after byte 98.
  task automatic load_image(input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_eq("start_in_gap", 32'(bus.start), 32'd0);
      end
      bus.rx_rdy  = 1'b1;
      bus.rx_data = img_buf[k];
      tick();
      bus.rx_rdy  = 1'b0;
      for (int j = 0; j < 8; j++) ref_mem[8*k + j] = img_buf[k][j];
      check_eq("start_after_byte", 32'(bus.start), 32'(k == NUM_BYTES - 1));
      check_eq("busy_loading", 32'(bus.busy), 32'd1);
    end
    if (nbytes == NUM_BYTES) begin
      tick();
      check_eq("start_one_cycle", 32'(bus.start), 32'd0);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < 1024; a++) begin
      bus.addr_input_unit = 10'(a);
      tick();
      check_eq("q_input", 32'(bus.q_input), (a < NUM_BITS) ? 32'(ref_mem[a]) : 32'd0);
    end
  endtask

  // done pulse, optional coincident byte, tx_rdy low for rdy_delay cycles, then the send.
  task automatic classify(input int d, input int rdy_delay, input bit with_rx);
    logic [7:0] exp_c;
    exp_c = expected_char(d);
    bus.done   = 1'b1;
    bus.digit  = 4'(d);
    bus.tx_rdy = 1'b0;
    if (with_rx) begin
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'($urandom);
    end
    tick();
    bus.done   = 1'b0;
    bus.rx_rdy = 1'b0;
    check_eq("tx_data_latched", 32'(bus.tx_data), 32'(exp_c));
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      check_eq("tx_start_held", 32'(bus.tx_start), 32'd0);
      check_eq("busy_wait_tx", 32'(bus.busy), 32'd1);
      check_eq("tx_data_held", 32'(bus.tx_data), 32'(exp_c));
    end
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    check_eq("tx_start_pulse", 32'(bus.tx_start), 32'd1);
    check_eq("tx_data_at_send", 32'(bus.tx_data), 32'(exp_c));
    check_eq("busy_drop", 32'(bus.busy), 32'd0);
    tick();
    check_eq("tx_start_single", 32'(bus.tx_start), 32'd0);
    check_eq("tx_data_after", 32'(bus.tx_data), 32'(exp_c));
    last_char = exp_c;
  endtask

  initial begin
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.addr_input_unit = '0;
    bus.done = 1'b0; bus.digit = '0; bus.tx_rdy = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) ref_mem[i] = 1'b0;

    repeat (3) tick();
    check_eq("rst_start", 32'(bus.start), 32'd0);
    check_eq("rst_q_input", 32'(bus.q_input), 32'd0);
    check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All-ones image, full readback, then digit 7 with transmitter ready.
    for (int k = 0; k < NUM_BYTES; k++) img_buf[k] = 8'hFF;
    load_image(NUM_BYTES);
    readback();
    classify(7, 0, 1'b0);

    // done while loading must not change the held character.
    bus.done = 1'b1; bus.digit = 4'd3;
    tick();
    bus.done = 1'b0;
    check_eq("done_in_load", 32'(bus.tx_data), 32'(last_char));

    // Sparse pattern, MSB set in the final byte.
    for (int k = 0; k < NUM_BYTES; k++) img_buf[k] = 8'h01;
    img_buf[NUM_BYTES-1] = 8'h80;
    load_image(NUM_BYTES);
    readback();
    classify(12, 5, 1'b0);

    // Partial image interrupted by reset, then a full random image.
    for (int k = 0; k < NUM_BYTES; k++) img_buf[k] = 8'($urandom);
    load_image(50);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_start", 32'(bus.start), 32'd0);
    check_eq("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NUM_BYTES; k++) img_buf[k] = 8'($urandom);
    load_image(NUM_BYTES);
    readback();

    // Bytes arriving while waiting for the core are dropped.
    for (int i = 0; i < 3; i++) begin
      bus.rx_rdy = 1'b1; bus.rx_data = 8'($urandom);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
      check_eq("no_start_in_wait", 32'(bus.start), 32'd0);
    end
    classify(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b1);
    readback();

    // Next image right after the send must need exactly a full image.
    for (int k = 0; k < NUM_BYTES; k++) img_buf[k] = 8'($urandom);
    load_image(NUM_BYTES);
    readback();
    classify(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_input_loader.md
Name: snn_input_loader

Overview:
Front-end companion to the SNN core. Collects a 28x28 binary image arriving as bytes from the UART receiver and unpacks it into a 784x1 input-unit memory. Pulses the core's start, then serves the core's bit reads (addr_input_unit -> q_input). Captures the core's digit on done and hands it to the UART transmitter as an ASCII character.

Parameters:
NUM_BITS, 784, number of input units (image pixels); must be a multiple of 8.
NUM_BYTES, NUM_BITS/8 (98), derived; bytes per image.
ASCII_BASE, 8'h30, added to a valid digit to form the transmitted character.
BAD_CHAR, 8'h3F, character sent when the digit is out of range (>9).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
start  out  1  one-cycle pulse to the core: image loaded
addr_input_unit  in  10  core read address
q_input  out  1  stored bit at addr_input_unit, registered
done  in  1  one-cycle pulse from the core: digit valid
digit  in  4  core classification result, sampled only on done
tx_rdy  in  1  transmitter idle, can accept a byte
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  8  character to transmit
busy  out  1  high from the first accepted byte until the cycle tx_start fires

Behaviour:
- Reset values: start=0, q_input=0, tx_start=0, tx_data=8'h00, busy=0, state=LOAD, byte_cnt=0. The bit memory is not reset.
- Unpacking: byte k (0-based) bit j is written to address 8k+j, LSB first. All 8 bits are written in the cycle rx_rdy is high.
- Read port: this port is independent of state.
  - q_input is registered: q_input(t+1) = mem[addr_input_unit(t)].
  - Addresses >= NUM_BITS return 0.
  - A read and a write to the same address in the same cycle return the old value.
- FSM states: LOAD, START, WAIT_DONE, SEND.
- LOAD:
  - On rx_rdy, write the byte and increment byte_cnt; busy goes high on the first byte.
  - When the byte with byte_cnt=NUM_BYTES-1 is accepted, clear byte_cnt and go to START.
- START: start=1 for exactly this one cycle, then WAIT_DONE. start therefore fires the cycle after the last rx_rdy.
- WAIT_DONE:
  - rx_rdy is ignored; those bytes are dropped, with no write and no count.
  - On done, register tx_data = (digit<=9) ? ASCII_BASE+digit : BAD_CHAR, then go to SEND.
- SEND:
  - When tx_rdy=1, pulse tx_start for one cycle with tx_data stable, drop busy, and go to LOAD.
  - While tx_rdy=0, wait indefinitely with tx_data held.
  - rx_rdy is ignored.
- done outside WAIT_DONE is ignored.
- rx_rdy and done in the same cycle in WAIT_DONE: done is taken and the byte is dropped.
- tx_data holds its last value after the send, until the next done.
- Reset asserted mid-load or mid-wait: returns to LOAD with byte_cnt=0. A partial image is discarded; the next image needs a full NUM_BYTES bytes.
- Back-to-back images: the first byte may arrive the cycle after tx_start.

Test Plan:
- 98 bytes of 8'hFF with gaps of 0-3 cycles -> start is high exactly one cycle, the cycle after the 98th rx_rdy. Reading addr 0..783 gives q_input=1 one cycle after each address. addr 784..1023 -> 0.
- 98 bytes of 8'h01 -> q_input=1 only at addresses 8k. Byte 8'h80 at k=97 -> addr 783=1, addr 776=0.
- done with digit=7, tx_rdy=1 -> tx_start pulse, tx_data=8'h37, busy falls the same cycle, state LOAD.
- done with digit=4'hC, tx_rdy held 0 for 5 cycles -> no tx_start until tx_rdy rises, then a single pulse with tx_data=8'h3F.
- Reset after 50 bytes, then 98 bytes -> no start before the 98th post-reset byte. Image bits written before reset are overwritten correctly.
- 3 rx_rdy pulses during WAIT_DONE, plus one coincident with done -> memory unchanged (verified by readback), byte_cnt still 0. The next image loads correctly after tx_start.
